// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad matrix scanner.
//   state_t     : scanner FSM states
//   NUM_ROWS/NUM_COLS, ROW_W/COL_W, CNT_W : matrix geometry and debounce counter width
//   lowest_col  : index of the lowest set bit of a column pattern (lowest column wins)
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned ROW_W    = 2;
  localparam int unsigned COL_W    = 2;
  localparam int unsigned CNT_W    = 4;

  // Lowest active column; an all-zero pattern maps to column 0 (never used that way).
  function automatic logic [COL_W-1:0] lowest_col(input logic [NUM_COLS-1:0] pat);
    logic [COL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (pat[i]) idx = COL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running scan prescaler; shareable between keypad and display scanners.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   tick : one-clk pulse while the prescaler is all-ones (every 2^DIV_W clk)
module scan_tick_gen #(
  parameter int unsigned DIV_W = 17
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  // Value one below all-ones: registering the compare makes tick coincide with all-ones.
  localparam logic [DIV_W-1:0] PRE_LAST = ~DIV_W'(1);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt + DIV_W'(1);
      tick <= (cnt == PRE_LAST);
    end
  end

endmodule

// File: rtl/keypad_matrix_scan.sv
// 4x4 keypad matrix scanner with column synchronisation and press/release debounce.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   col_in    : column lines, active-low, asynchronous
//   row_out   : row drive, active-low, exactly one row low
//   key_code  : last confirmed key, {row, col}
//   key_valid : one-clk strobe on each newly confirmed press
//   key_held  : high from confirm until the release is confirmed
module keypad_matrix_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV_W     = 17,
  parameter int unsigned DEBOUNCE_TICKS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COLS-1:0] col_in,
  output logic [NUM_ROWS-1:0] row_out,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DEBOUNCE_TICKS);

  logic                tick;
  logic [NUM_COLS-1:0] col_meta;
  logic [NUM_COLS-1:0] col_s;
  logic [NUM_COLS-1:0] active;
  logic                any_press;
  state_t              state;
  logic [ROW_W-1:0]    row;
  logic [ROW_W-1:0]    nxt_row;
  logic [NUM_COLS-1:0] lat_pat;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;

  scan_tick_gen #(.DIV_W(SCAN_DIV_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchroniser; idle level is all-high (pull-ups).
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= '1;
      col_s    <= '1;
    end else begin
      col_meta <= col_in;
      col_s    <= col_meta;
    end
  end

  assign active    = ~col_s;
  assign any_press = |active;
  assign nxt_row   = row + ROW_W'(1);
  assign cnt_inc   = cnt + CNT_W'(1);

  // Scanner FSM; everything except the key_valid drop advances only on tick.
  // The entry tick already counts as one stable sample, so confirmation uses >=
  // on the incremented count, which also lets DEBOUNCE_TICKS=1 confirm on the
  // first tick after entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      row       <= '0;
      row_out   <= 4'b1110;
      lat_pat   <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (any_press) begin
              lat_pat <= active;
              cnt     <= CNT_W'(1);
              state   <= DEBOUNCE;
            end else begin
              row     <= nxt_row;
              row_out <= ~(NUM_ROWS'(1) << nxt_row);
            end
          end
          DEBOUNCE: begin
            if (active == lat_pat) begin
              if (cnt_inc >= DB_LIM) begin
                key_code  <= {row, lowest_col(lat_pat)};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= HOLD;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= SCAN;
            end
          end
          HOLD: begin
            if (!any_press) begin
              cnt   <= CNT_W'(1);
              state <= RELEASE;
            end
          end
          RELEASE: begin
            if (any_press) begin
              state <= HOLD;
            end else if (cnt_inc >= DB_LIM) begin
              key_held <= 1'b0;
              state    <= SCAN;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Directed bench for keypad_matrix_scan with SCAN_DIV_W=2 and DEBOUNCE_TICKS=3.
// A behavioural matrix drives col_in from the modelled pressed keys and row_out.
module tb_keypad_matrix_scan;

  logic       clk;
  logic       rst;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;   // bit r*4+c set when key (r,c) is held down
  int          ph;        // clk edges since last reset edge
  int          vcount;    // clk cycles observed with key_valid high
  int          n_assert;
  int          n_fail;

  keypad_matrix_scan #(
    .SCAN_DIV_W     (2),
    .DEBOUNCE_TICKS (3)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a column reads low when a pressed key sits on a driven row.
  always_comb begin
    col_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) ph <= 0;
    else     ph <= ph + 1;
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) vcount <= vcount + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next edge on which the DUT processes a tick.
  task automatic next_tick();
    do begin
      @(posedge clk);
      #1;
    end while (ph % 4 != 0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    vcount   = 0;
    pressed  = '0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1. Reset state and free scanning
    check("rst_row",   8'(row_out),   8'hE);
    check("rst_code",  8'(key_code),  8'h0);
    check("rst_valid", 8'(key_valid), 8'h0);
    check("rst_held",  8'(key_held),  8'h0);
    rst = 1'b0;
    next_tick(); check("scan_r1", 8'(row_out), 8'hD);
    next_tick(); check("scan_r2", 8'(row_out), 8'hB);
    next_tick(); check("scan_r3", 8'(row_out), 8'h7);
    next_tick(); check("scan_r0", 8'(row_out), 8'hE);
    check("scan_held", 8'(key_held), 8'h0);
    check("scan_vcnt", 8'(vcount),   8'h0);

    // 2. Stable press of key (2,1)
    pressed[9] = 1'b1;
    next_tick(); check("k9_r1", 8'(row_out), 8'hD);
    next_tick(); check("k9_r2", 8'(row_out), 8'hB);
    next_tick(); check("k9_freeze", 8'(row_out), 8'hB);
    check("k9_entry_held", 8'(key_held), 8'h0);
    next_tick(); check("k9_tick2_valid", 8'(key_valid), 8'h0);
    check("k9_tick2_row", 8'(row_out), 8'hB);
    next_tick(); check("k9_confirm_valid", 8'(key_valid), 8'h1);
    check("k9_code", 8'(key_code), 8'h9);
    check("k9_held", 8'(key_held), 8'h1);
    @(posedge clk); #1;
    check("k9_valid_drop", 8'(key_valid), 8'h0);
    check("k9_vcnt", 8'(vcount), 8'h1);

    // 4. Extra column in HOLD, then release
    pressed[11] = 1'b1;
    next_tick(); check("hold_valid", 8'(key_valid), 8'h0);
    check("hold_held", 8'(key_held), 8'h1);
    check("hold_code", 8'(key_code), 8'h9);
    next_tick();
    pressed = '0;
    next_tick(); check("rel_t1_held", 8'(key_held), 8'h1);
    next_tick(); check("rel_t2_held", 8'(key_held), 8'h1);
    next_tick(); check("rel_t3_held", 8'(key_held), 8'h0);
    check("rel_row", 8'(row_out), 8'hB);
    check("rel_vcnt", 8'(vcount), 8'h1);
    next_tick(); check("rel_resume", 8'(row_out), 8'h7);

    // 3. Bounce on key (0,2): two ticks of press, then release
    pressed[2] = 1'b1;
    next_tick(); check("bnc_r0", 8'(row_out), 8'hE);
    next_tick(); check("bnc_entry", 8'(row_out), 8'hE);
    next_tick(); check("bnc_t2", 8'(row_out), 8'hE);
    pressed = '0;
    next_tick(); check("bnc_abort_row", 8'(row_out), 8'hE);
    next_tick(); check("bnc_resume_r1", 8'(row_out), 8'hD);
    check("bnc_vcnt", 8'(vcount),   8'h1);
    check("bnc_code", 8'(key_code), 8'h9);
    check("bnc_held", 8'(key_held), 8'h0);

    // 5. Keys (3,0) and (3,3) together: lowest column wins
    pressed[12] = 1'b1;
    pressed[15] = 1'b1;
    next_tick(); check("mk_r2", 8'(row_out), 8'hB);
    next_tick(); check("mk_r3", 8'(row_out), 8'h7);
    next_tick(); check("mk_entry", 8'(row_out), 8'h7);
    next_tick(); check("mk_t2_valid", 8'(key_valid), 8'h0);
    next_tick(); check("mk_valid", 8'(key_valid), 8'h1);
    check("mk_code", 8'(key_code), 8'hC);
    check("mk_held", 8'(key_held), 8'h1);
    repeat (3) @(posedge clk);
    #1;
    check("mk_vcnt", 8'(vcount), 8'h2);
    next_tick();
    pressed = '0;
    next_tick(); next_tick(); next_tick();
    check("mk_rel_held", 8'(key_held), 8'h0);
    next_tick(); check("mk_resume", 8'(row_out), 8'hE);

    // 6. Reset mid-DEBOUNCE on key (0,0)
    pressed[0] = 1'b1;
    next_tick(); check("rd_entry", 8'(row_out), 8'hE);
    next_tick();
    rst     = 1'b1;
    pressed = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rd_row",   8'(row_out),   8'hE);
    check("rd_held",  8'(key_held),  8'h0);
    check("rd_valid", 8'(key_valid), 8'h0);
    check("rd_code",  8'(key_code),  8'h0);
    next_tick(); check("rd_scan_r1", 8'(row_out), 8'hD);
    next_tick(); next_tick();
    check("rd_vcnt",  8'(vcount),   8'h2);
    check("rd_code2", 8'(key_code), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
